aes_round_ctrl: RTL and testbench
=================================

# aes_round_ctrl

Control sequencer for the iterative AES-128 encryption datapath in the capstone top level. It accepts one plaintext/key block per handshake and issues the load strobe. It then steps the shared round datapath and key-expansion registers through NUM_ROUNDS rounds, one round per clock. Finally it holds the finished ciphertext valid until the consumer accepts it. It contains no data registers; the 128-bit state and round-key registers live in the datapath and obey this block's strobes.

## Interface

Parameters:
- NUM_ROUNDS, 10: rounds per block (10 = AES-128); legal 1..15.
- CNT_W, 16: width of the completed-block counter.

Ports:
- clk  in  1  system clock (CLOCK_50 at top level).
- rst_n  in  1  reset, synchronous, active-low; one clock; reset is synchronous and active-low.
- in_valid  in  1  plaintext and cipher key are present on the datapath inputs.
- in_ready  out  1  controller can accept a block this cycle.
- out_valid  out  1  ciphertext on the datapath output is final.
- out_ready  in  1  consumer takes the ciphertext this cycle.
- abort  in  1  cancel the block currently in rounds.
- ld  out  1  datapath loads state <= plaintext ^ key and round key <= key at the next edge.
- rnd_en  out  1  datapath applies one round and advances the key schedule at the next edge.
- round  out  4  current round index (1..NUM_ROUNDS) for the rcon lookup; 0 when not in rounds.
- last_rnd  out  1  current round omits MixColumns.
- busy  out  1  a block is in rounds or awaiting output acceptance.
- blk_cnt  out  CNT_W  completed (accepted) blocks, modulo 2^CNT_W.

## Operation

- FSM states: IDLE, ROUND, DONE. Registered state; `round` and `blk_cnt` are registered.
- Handshakes:
  - Input transfer: in_valid & in_ready at a rising edge.
  - Output transfer: out_valid & out_ready at a rising edge.
- IDLE:
  - in_ready=1; ld = in_valid (combinational).
  - On input transfer: go to ROUND with round <= 1.
- ROUND:
  - rnd_en=1; last_rnd = (round == NUM_ROUNDS).
  - If round < NUM_ROUNDS, round increments. At round == NUM_ROUNDS: go to DONE with round <= 0.
  - in_ready=0, out_valid=0.
- DONE:
  - out_valid=1; in_ready = out_ready; ld = out_ready & in_valid.
  - On output transfer: blk_cnt increments, wrapping to 0 after all-ones.
  - Output transfer plus input transfer: go to ROUND, round <= 1 (back-to-back; the datapath state is overwritten only after the output was sampled).
  - Output transfer only: go to IDLE.
  - No output transfer: hold, with all datapath strobes low.
- busy = (state != IDLE).
- abort:
  - Effective only in ROUND: next state IDLE, round <= 0, no blk_cnt change. rnd_en is still 1 in that cycle; the datapath contents are don't-care.
  - Ignored in IDLE and DONE; a completed result is always delivered.
- Reset (rst_n low at an edge, any state, including mid-round or DONE): state IDLE, round 0, blk_cnt 0. The block in flight is discarded.
- Outputs while rst_n is low: in_ready 0, ld 0, rnd_en 0, out_valid 0, last_rnd 0, busy 0.

## Timing

- Input transfer at edge T (ld high in the cycle before T).
  - rnd_en high in cycles T..T+NUM_ROUNDS-1, with round = 1..NUM_ROUNDS.
  - last_rnd high only in cycle T+NUM_ROUNDS-1.
  - out_valid rises after edge T+NUM_ROUNDS.
- Latency from input transfer to out_valid is NUM_ROUNDS edges (10). out_valid high for N+1 cycles if out_ready is withheld N cycles.
- Sustained throughput with out_ready=1 and in_valid=1: one block per NUM_ROUNDS+1 cycles (11).
- All strobes are mutually exclusive: at most one of ld and rnd_en per cycle.
- blk_cnt updates at the output-transfer edge.

## Test plan

- Single block, NUM_ROUNDS=10: reset 4 cycles, then in_valid pulse in IDLE. Required: ld for 1 cycle; rnd_en for 10 cycles with round 1..10; last_rnd only at round 10; out_valid 1 cycle later. With out_ready=1: blk_cnt=1, back to IDLE.
- Backpressure: out_ready low 5 cycles in DONE. Required: out_valid held 6 cycles, no rnd_en/ld, in_ready=0; blk_cnt increments exactly once on acceptance.
- Back-to-back: in_valid and out_ready held 1 for 3 blocks. Required: ld coincides with each output transfer; out_valid pulses spaced 11 cycles; blk_cnt=3.
- Abort at round 5: required IDLE next cycle, round=0, out_valid never asserted, blk_cnt unchanged. Next block completes normally. abort asserted in DONE is ignored, and the result is still delivered.
- Reset mid-operation: rst_n low during round 7, then in DONE. Required: all outputs at reset values the next cycle, blk_cnt=0.
- Counter wrap, CNT_W=2: 5 accepted blocks give blk_cnt sequence 1,2,3,0,1.

Source files
------------

// File: rtl/aes_round_ctrl.sv
// Control sequencer for the iterative AES-128 datapath: accepts a block,
// steps NUM_ROUNDS rounds one per clock, then holds the ciphertext valid until accepted.
module aes_round_ctrl #(
  parameter int unsigned NUM_ROUNDS = 10,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             abort,
  output logic             ld,
  output logic             rnd_en,
  output logic [3:0]       round,
  output logic             last_rnd,
  output logic             busy,
  output logic [CNT_W-1:0] blk_cnt
);

  localparam int unsigned RND_W = 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROUND = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [RND_W-1:0] round_q, round_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State, round index and completed-block counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      round_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and strobe decode; strobes are forced low while reset is held
  always_comb begin
    state_d   = state_q;
    round_d   = round_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    rnd_en    = 1'b0;
    last_rnd  = 1'b0;
    ld        = 1'b0;

    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = S_ROUND;
          round_d = RND_W'(1);
        end
      end

      S_ROUND: begin
        rnd_en   = 1'b1;
        last_rnd = (round_q == RND_W'(NUM_ROUNDS));
        if (abort) begin
          state_d = S_IDLE;
          round_d = '0;
        end else if (round_q == RND_W'(NUM_ROUNDS)) begin
          state_d = S_DONE;
          round_d = '0;
        end else begin
          round_d = round_q + RND_W'(1);
        end
      end

      S_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (in_valid) begin
            state_d = S_ROUND;
            round_d = RND_W'(1);
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        round_d = '0;
      end
    endcase

    ld = in_ready & in_valid;

    if (!rst_n) begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      rnd_en    = 1'b0;
      last_rnd  = 1'b0;
      ld        = 1'b0;
    end
  end

  assign round   = round_q;
  assign busy    = rst_n & (state_q != S_IDLE);
  assign blk_cnt = cnt_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl; a queue holds the expected completed-block
// count for each accepted input and is checked when the ciphertext is taken.
module tb_aes_round_ctrl;

  localparam int unsigned N = 10;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, out_ready, abort;
  logic        in_ready, out_valid, ld, rnd_en, last_rnd, busy;
  logic [3:0]  round;
  logic [15:0] blk_cnt;

  logic        w_in_ready, w_out_valid, w_ld, w_rnd_en, w_last_rnd, w_busy;
  logic [3:0]  w_round;
  logic [1:0]  w_blk_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int issued = 0;
  int acc = 0;
  int cyc = 0;
  int exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_round_ctrl #(.NUM_ROUNDS(N), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .abort(abort), .ld(ld),
    .rnd_en(rnd_en), .round(round), .last_rnd(last_rnd), .busy(busy),
    .blk_cnt(blk_cnt)
  );

  aes_round_ctrl #(.NUM_ROUNDS(N), .CNT_W(2)) u_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
    .out_valid(w_out_valid), .out_ready(out_ready), .abort(abort), .ld(w_ld),
    .rnd_en(w_rnd_en), .round(w_round), .last_rnd(w_last_rnd), .busy(w_busy),
    .blk_cnt(w_blk_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare the counters against the oldest outstanding expectation
  task automatic pop_check(input string tag);
    int e;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_blk_cnt"}, 32'(blk_cnt), 32'(e[15:0]));
      chk({tag, "_wrap_cnt"}, 32'(w_blk_cnt), 32'(e[1:0]));
      acc = e;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_ld", 32'(ld), 0);
    chk("rst_rnd_en", 32'(rnd_en), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_last_rnd", 32'(last_rnd), 0);
    chk("rst_busy", 32'(busy), 0);
    step();
    chk("rst_round", 32'(round), 0);
    chk("rst_blk_cnt", 32'(blk_cnt), 0);
    chk("rst_wrap_cnt", 32'(w_blk_cnt), 0);
    rst_n = 1'b1;
    #1;
    chk("rst_rel_in_ready", 32'(in_ready), 1);
    chk("rst_rel_busy", 32'(busy), 0);
    exp_q.delete();
    issued = 0;
    acc = 0;
  endtask

  // Launch from IDLE: ld must be visible in the cycle before the transfer edge
  task automatic launch();
    in_valid = 1'b1;
    #1;
    chk("launch_ld", 32'(ld), 1);
    chk("launch_in_ready", 32'(in_ready), 1);
    chk("launch_busy", 32'(busy), 0);
    chk("launch_rnd_en", 32'(rnd_en), 0);
    step();
    in_valid = 1'b0;
    issued++;
    exp_q.push_back(issued);
  endtask

  task automatic rounds(input int first, input int last);
    for (int r = first; r <= last; r++) begin
      #1;
      chk("rnd_en", 32'(rnd_en), 1);
      chk("rnd_idx", 32'(round), 32'(r));
      chk("rnd_last", 32'(last_rnd), 32'(r == int'(N)));
      chk("rnd_out_valid", 32'(out_valid), 0);
      chk("rnd_in_ready", 32'(in_ready), 0);
      chk("rnd_ld", 32'(ld), 0);
      chk("rnd_busy", 32'(busy), 1);
      step();
    end
  endtask

  // Full block with the consumer withholding out_ready for `hold` cycles
  task automatic do_block(input int hold, input bit ab_done);
    launch();
    rounds(1, N);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      abort    = ab_done;
      #1;
      chk("hold_out_valid", 32'(out_valid), 1);
      chk("hold_in_ready", 32'(in_ready), 0);
      chk("hold_ld", 32'(ld), 0);
      chk("hold_rnd_en", 32'(rnd_en), 0);
      chk("hold_round", 32'(round), 0);
      chk("hold_blk_cnt", 32'(blk_cnt), 32'(acc[15:0]));
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("acc_out_valid", 32'(out_valid), 1);
    chk("acc_in_ready", 32'(in_ready), 1);
    chk("acc_ld", 32'(ld), 0);
    step();
    out_ready = 1'b0;
    abort     = 1'b0;
    pop_check("acc");
    chk("post_busy", 32'(busy), 0);
    chk("post_out_valid", 32'(out_valid), 0);
    chk("post_in_ready", 32'(in_ready), 1);
  endtask

  initial begin
    int t_prev;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; abort = 1'b0;
    repeat (3) step();
    do_reset();

    // Single block, then backpressure with abort ignored in DONE
    do_block(0, 1'b0);
    do_block(5, 1'b0);
    do_block(2, 1'b1);

    // Back-to-back blocks: ld coincides with each output transfer
    t_prev = 0;
    launch();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      rounds(1, N);
      if (b == 2) in_valid = 1'b0;
      #1;
      chk("b2b_out_valid", 32'(out_valid), 1);
      chk("b2b_ld", 32'(ld), 32'(b < 2));
      if (b > 0) chk("b2b_spacing", 32'(cyc - t_prev), 32'(N + 1));
      t_prev = cyc;
      step();
      pop_check("b2b");
      if (b < 2) begin
        issued++;
        exp_q.push_back(issued);
      end
    end
    out_ready = 1'b0;
    chk("b2b_total", 32'(blk_cnt), 32'd6);
    chk("b2b_idle", 32'(busy), 0);

    // Abort at round 5 discards the block
    launch();
    rounds(1, 4);
    abort = 1'b1;
    #1;
    chk("abort_round", 32'(round), 5);
    chk("abort_rnd_en", 32'(rnd_en), 1);
    step();
    abort = 1'b0;
    void'(exp_q.pop_back());
    issued--;
    for (int i = 0; i < 12; i++) begin
      chk("abort_busy", 32'(busy), 0);
      chk("abort_round0", 32'(round), 0);
      chk("abort_out_valid", 32'(out_valid), 0);
      chk("abort_blk_cnt", 32'(blk_cnt), 32'(acc[15:0]));
      step();
    end
    do_block(0, 1'b0);

    // Reset during round 7, then reset while in DONE
    launch();
    rounds(1, 6);
    do_reset();
    launch();
    rounds(1, N);
    #1;
    chk("done_before_rst", 32'(out_valid), 1);
    do_reset();

    // CNT_W=2 counter wraps 1,2,3,0,1 over five accepted blocks
    for (int k = 0; k < 5; k++) do_block(0, 1'b0);
    chk("wrap_final", 32'(w_blk_cnt), 32'd1);
    chk("wide_final", 32'(blk_cnt), 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
